// File: rtl/pixel_row_loader.sv
// pixel_row_loader: packs a serial 1-bit pixel stream into NrOfBits-wide
// row words, MSB first. Each word is committed into a bank of clock-enabled
// row registers through a one-hot row write enable that is qualified by the
// shared Tick. The bank is cleared before each frame, and a pulse marks the
// commit of the last row.
module pixel_row_loader #(
  parameter int NrOfBits = 28,
  parameter int NrOfRows = 28
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                start,
  input  logic                pix_in,
  input  logic                pix_valid,
  output logic                pix_ready,
  output logic [NrOfBits-1:0] D_out,
  output logic [NrOfRows-1:0] row_we,
  output logic                clr_out,
  output logic                busy,
  output logic                frame_done
);

  localparam int CW = (NrOfBits > 1) ? $clog2(NrOfBits) : 1;
  localparam int RW = (NrOfRows > 1) ? $clog2(NrOfRows) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(NrOfBits - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(NrOfRows - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, COMMIT, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [NrOfBits-1:0] shift;
  logic                accept;
  logic [CW-1:0]       bit_idx;

  // A pixel moves only when the source offers it on an enabled LOAD cycle.
  assign accept  = (state == LOAD) && pix_valid && Tick;
  // The first pixel of a row lands in the MSB.
  assign bit_idx = COL_LAST - col;

  // Frame sequencing, column/row counting and row packing.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      shift <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= CLEAR;
        end
        CLEAR: begin
          row   <= '0;
          col   <= '0;
          shift <= '0;
          state <= LOAD;
        end
        LOAD: begin
          if (accept) begin
            shift[bit_idx] <= pix_in;
            if (col == COL_LAST) begin
              col   <= '0;
              state <= COMMIT;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        COMMIT: begin
          // The word is held until the row registers are enabled.
          if (Tick) begin
            shift <= '0;
            if (row == ROW_LAST) begin
              state <= DONE;
            end else begin
              row   <= row + 1'b1;
              state <= LOAD;
            end
          end
        end
        DONE: begin
          row   <= '0;
          col   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status and handshake outputs decoded from the registered state.
  always_comb begin
    pix_ready  = (state == LOAD) && Tick;
    D_out      = (state == COMMIT) ? shift : '0;
    clr_out    = (state == CLEAR);
    busy       = (state != IDLE);
    frame_done = (state == DONE);
  end

  // One-hot row enable, fired only on the Tick cycle of COMMIT.
  always_comb begin
    row_we = '0;
    for (int i = 0; i < NrOfRows; i++)
      row_we[i] = (state == COMMIT) && Tick && (row == RW'(i));
  end

endmodule

// File: tb/tb_pixel_row_loader.sv
// Bench for pixel_row_loader: random pixel frames are generated up front.
// Each row's expected word is pushed into a scoreboard. A negedge monitor
// pops and checks every row_we pulse, and also checks the handshake and
// hold rules on every cycle.
module tb_pixel_row_loader;
  localparam int NB = 28;
  localparam int NR = 28;

  logic          clk = 0;
  logic          Reset = 1, Tick = 0, start = 0, pix_in = 0, pix_valid = 0;
  logic          pix_ready, clr_out, busy, frame_done;
  logic [NB-1:0] D_out;
  logic [NR-1:0] row_we;

  always #5 clk = ~clk;

  pixel_row_loader #(.NrOfBits(NB), .NrOfRows(NR)) dut (
    .Clock(clk), .Reset(Reset), .Tick(Tick), .start(start), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .D_out(D_out), .row_we(row_we),
    .clr_out(clr_out), .busy(busy), .frame_done(frame_done));

  typedef struct { int row; logic [NB-1:0] word; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, tick_div = 1;
  int clr_cnt = 0, commit_cnt = 0, done_cnt = 0, first_busy = 0;
  bit chk_lat = 0, busy_q = 0, hold_q = 0;
  logic [NB-1:0] d_q = '0;
  exp_t e_m;
  logic [NR-1:0] we_m;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick generator: high every cycle, or one cycle in tick_div.
  initial begin
    int t;
    t = 0;
    forever begin
      @(posedge clk); #1;
      t++;
      Tick = (tick_div <= 1) ? 1'b1 : ((t % tick_div) == 0);
    end
  end

  // Monitor: scoreboard pops on commits, plus per-cycle rule checks.
  always @(negedge clk) begin
    if (row_we != '0) begin
      commit_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL commit_unexpected: row_we=%h D_out=%h, no row expected", row_we, D_out);
      end else begin
        e_m  = exp_q.pop_front();
        we_m = NR'(1) << e_m.row;
        if (row_we !== we_m || D_out !== e_m.word || Tick !== 1'b1) begin
          n_err++;
          $display("FAIL commit_row%0d: got row_we=%h D_out=%h tick=%b, want row_we=%h D_out=%h tick=1",
                   e_m.row, row_we, D_out, Tick, we_m, e_m.word);
        end
      end
    end
    if (clr_out) clr_cnt++;
    if (busy && !busy_q) first_busy = cyc;
    if (frame_done) begin
      done_cnt++;
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL frame_done_early: %0d rows pending, want 0", exp_q.size());
      end
      if (chk_lat) begin
        n_cmp++;
        if (cyc - first_busy + 1 != 2 + NR * (NB + 1)) begin
          n_err++;
          $display("FAIL frame_latency: got %0d cycles, want %0d", cyc - first_busy + 1, 2 + NR * (NB + 1));
        end
      end
    end
    if (!busy) begin
      n_cmp++;
      if ({pix_ready, D_out, row_we, clr_out, frame_done} !== '0) begin
        n_err++;
        $display("FAIL idle_outputs: ready=%b D_out=%h row_we=%h clr=%b done=%b, want all 0",
                 pix_ready, D_out, row_we, clr_out, frame_done);
      end
    end
    if (!Tick) begin
      n_cmp++;
      if (pix_ready !== 1'b0) begin
        n_err++;
        $display("FAIL ready_without_tick: pix_ready=%b, want 0", pix_ready);
      end
    end
    if (hold_q) begin
      n_cmp++;
      if (D_out !== d_q) begin
        n_err++;
        $display("FAIL commit_hold: D_out=%h, want held %h", D_out, d_q);
      end
    end
    if (D_out != '0) begin
      n_cmp++;
      if (pix_ready !== 1'b0) begin
        n_err++;
        $display("FAIL ready_in_commit: pix_ready=%b, want 0", pix_ready);
      end
    end
    hold_q = (D_out != '0) && (row_we == '0);
    d_q    = D_out;
    busy_q = busy;
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // pmode: 0 = pixel number k (from 1) mod 2, 1 = all ink, 2 = random.
  // vmode: 0 = always valid, 1 = toggling valid, 2 = random valid.
  task automatic run_frame(input int pmode, input int vmode, input bit spam,
                           input int abort_at, input bit lat);
    logic          px [NB*NR];
    logic [NB-1:0] w;
    logic          p;
    int            k, budget, c0, m0, d0;
    bit            acc;
    @(posedge clk); #1;
    for (int r = 0; r < NR; r++) begin
      w = '0;
      for (int c = 0; c < NB; c++) begin
        p = (pmode == 0) ? logic'((r * NB + c + 1) % 2) :
            (pmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        px[r * NB + c] = p;
        w[NB - 1 - c]  = p;
      end
      exp_q.push_back('{row: r, word: w});
    end
    c0 = clr_cnt; m0 = commit_cnt; d0 = done_cnt;
    chk_lat = lat;
    start = 1; pix_in = px[0]; pix_valid = 1;
    k = 0; budget = 0;
    while (k < NB * NR && budget < 20000) begin
      @(negedge clk);
      acc = pix_valid && pix_ready;
      if (acc) k++;
      @(posedge clk); #1;
      budget++;
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      if (abort_at >= 0 && k == abort_at) break;
      if (k < NB * NR) begin
        pix_in = px[k];
        if (acc || !pix_valid)
          pix_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? !pix_valid : 1'($urandom_range(0, 1));
      end else begin
        pix_valid = 0;
      end
    end
    start = 0;
    if (abort_at >= 0) begin
      Reset = 1; pix_valid = 0;
      @(posedge clk); #1;
      Reset = 0;
      @(negedge clk);
      n_cmp++;
      if ({busy, pix_ready, D_out, row_we, clr_out, frame_done} !== '0) begin
        n_err++;
        $display("FAIL reset_midframe: busy=%b ready=%b D_out=%h row_we=%h clr=%b done=%b, want all 0",
                 busy, pix_ready, D_out, row_we, clr_out, frame_done);
      end
      check("abort_commits", commit_cnt - m0, abort_at / NB);
      check("abort_clr", clr_cnt - c0, 1);
      exp_q.delete();
      chk_lat = 0;
      return;
    end
    check("pixels_accepted", k, NB * NR);
    budget = 0;
    while (done_cnt == d0 && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    check("frame_done_seen", done_cnt - d0, 1);
    @(negedge clk);
    check("busy_after_done", int'(busy), 0);
    check("clr_pulses", clr_cnt - c0, 1);
    check("row_commits", commit_cnt - m0, NR);
    chk_lat = 0;
  endtask

  initial begin
    Reset = 1;
    repeat (2) @(posedge clk);
    #1 Reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_ready", int'(pix_ready), 0);
    check("reset_outputs", int'({D_out, row_we, clr_out, frame_done} != '0), 0);

    run_frame(0, 0, 0, -1, 1);   // alternating pixels, full rate, latency
    run_frame(1, 1, 0, -1, 0);   // toggling valid, all ink
    tick_div = 4;
    run_frame(2, 2, 0, -1, 0);   // Tick one cycle in four
    tick_div = 1;
    run_frame(2, 0, 0, 5 * NB + 10, 0);  // reset at row 5, col 10
    run_frame(0, 0, 0, -1, 1);   // fresh frame after the reset
    run_frame(2, 2, 1, -1, 0);   // start toggled while busy

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
